// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller:
//   SEG_OFF      - active-low "all segments dark" pattern (dp included)
//   scan_state_t - scan sequencer states
//   digit_t      - 3-bit digit value
//   next_ptr()   - digit pointer advance with wrap at the last position
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_LOAD  = 2'd1,
    S_SHOW  = 2'd2,
    S_GUARD = 2'd3
  } scan_state_t;

  typedef logic [2:0] digit_t;

  // Advance the scan pointer, wrapping to 0 after the last populated digit.
  function automatic logic [2:0] next_ptr(input logic [2:0] p, input logic [2:0] last);
    logic [2:0] r;
    if (p == last) begin
      r = 3'd0;
    end else begin
      r = p + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_regfile.sv
// ---------------------------------------------------------------------------
// seg7_regfile
// Per-digit value/blank storage with one write port and one async read port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr_en               - write strobe (handshake already qualified)
//   wr_idx/wr_val/wr_blank - write address and data; idx >= NDIG is dropped
//   rd_idx              - read address (scan pointer)
//   rd_val/rd_blank     - combinational read data
// Reset leaves every digit at value 0 and blanked.
// ---------------------------------------------------------------------------
module seg7_regfile
  import seg7_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  digit_t     wr_val,
  input  logic       wr_blank,
  input  logic [2:0] rd_idx,
  output digit_t     rd_val,
  output logic       rd_blank
);

  digit_t r_val   [NDIG];
  logic   r_blank [NDIG];

  // Storage update: reset to dark zeros, otherwise write the addressed digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        r_val[i]   <= 3'd0;
        r_blank[i] <= 1'b1;
      end
    end else begin
      // Out-of-range indices match no entry and are silently discarded.
      for (int i = 0; i < NDIG; i++) begin
        if (wr_en && (wr_idx == 3'(i))) begin
          r_val[i]   <= wr_val;
          r_blank[i] <= wr_blank;
        end
      end
    end
  end

  // Async read mux built as an AND-OR so no index-width truncation is needed.
  always_comb begin
    rd_val   = 3'd0;
    rd_blank = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      rd_val   = rd_val   | ({3{rd_idx == 3'(i)}} & r_val[i]);
      rd_blank = rd_blank | ((rd_idx == 3'(i)) & r_blank[i]);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan of NDIG digits through one external 3-to-7 decoder.
// Each slot is DIV cycles: 1 LOAD + (DIV-GUARD-1) SHOW + GUARD dark cycles.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - scan enable; low forces the display dark, pointer held
//   wr_valid/wr_ready, wr_idx/wr_val/wr_blank - digit register write port
//   dec_b           - registered value presented to the shared decoder
//   dec_h           - decoder result, active-low segments, bit 0 = dp
//   seg_o           - registered active-low segments
//   an_o            - registered active-low digit enables, at most one low
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int GUARD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2:0]      wr_idx,
  input  logic [2:0]      wr_val,
  input  logic            wr_blank,
  output logic [2:0]      dec_b,
  input  logic [7:0]      dec_h,
  output logic [7:0]      seg_o,
  output logic [NDIG-1:0] an_o
);

  localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   SHOW_LAST = CW'(DIV - GUARD - 1);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(DIV - 1);
  localparam logic [2:0]      PTR_LAST  = 3'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF    = {NDIG{1'b1}};

  scan_state_t     r_state, w_state;
  logic [2:0]      r_ptr, w_ptr;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_cur_blank, w_cur_blank;
  digit_t          r_dec_b, w_dec_b;
  logic [7:0]      r_seg, w_seg;
  logic [NDIG-1:0] r_an, w_an;
  logic [NDIG-1:0] w_an_lit;
  digit_t          w_rd_val;
  logic            w_rd_blank;
  logic            w_wr_fire;

  // The port is ready in every non-reset cycle, so writes during rst drop.
  assign wr_ready  = ~rst;
  assign w_wr_fire = wr_valid & ~rst;

  seg7_regfile #(
    .NDIG (NDIG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr_fire),
    .wr_idx   (wr_idx),
    .wr_val   (wr_val),
    .wr_blank (wr_blank),
    .rd_idx   (r_ptr),
    .rd_val   (w_rd_val),
    .rd_blank (w_rd_blank)
  );

  // One-cold digit enable for the digit under the pointer.
  always_comb begin
    w_an_lit = AN_OFF;
    for (int i = 0; i < NDIG; i++) begin
      if (r_ptr == 3'(i)) begin
        w_an_lit[i] = 1'b0;
      end else begin
        w_an_lit[i] = 1'b1;
      end
    end
  end

  // Scan sequencer next-state and next-output logic; outputs default dark.
  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_cnt       = r_cnt;
    w_cur_blank = r_cur_blank;
    w_dec_b     = r_dec_b;
    w_seg       = SEG_OFF;
    w_an        = AN_OFF;
    if (!en) begin
      w_state = S_OFF;
      w_cnt   = CNT_ZERO;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state = S_LOAD;
        end
        S_LOAD: begin
          // Latch the slot content; later writes wait for the next LOAD.
          w_cur_blank = w_rd_blank;
          w_dec_b     = w_rd_val;
          w_cnt       = CNT_ONE;
          w_state     = S_SHOW;
        end
        S_SHOW: begin
          // dec_b has been stable since LOAD, so dec_h is settled here.
          if (r_cur_blank) begin
            w_seg = SEG_OFF;
            w_an  = AN_OFF;
          end else begin
            w_seg = dec_h;
            w_an  = w_an_lit;
          end
          w_cnt = r_cnt + CNT_ONE;
          if (r_cnt == SHOW_LAST) begin
            w_state = S_GUARD;
          end else begin
            w_state = S_SHOW;
          end
        end
        S_GUARD: begin
          if (r_cnt == SLOT_LAST) begin
            w_ptr   = next_ptr(r_ptr, PTR_LAST);
            w_cnt   = CNT_ZERO;
            w_state = S_LOAD;
          end else begin
            w_cnt   = r_cnt + CNT_ONE;
            w_state = S_GUARD;
          end
        end
        default: begin
          w_state = S_OFF;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset to the dark state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_ptr       <= 3'd0;
      r_cnt       <= CNT_ZERO;
      r_cur_blank <= 1'b1;
      r_dec_b     <= 3'd0;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_cnt       <= w_cnt;
      r_cur_blank <= w_cur_blank;
      r_dec_b     <= w_dec_b;
      r_seg       <= w_seg;
      r_an        <= w_an;
    end
  end

  assign dec_b = r_dec_b;
  assign seg_o = r_seg;
  assign an_o  = r_an;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Scoreboard bench: a slot-schedule model pushes the expected outputs each
// clock; a monitor pops and compares them shortly after every rising edge.
// The board decoder is emulated here from dec_b.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       rst, en, wr_valid, wr_blank;
  logic [2:0] wr_idx, wr_val, dec_b;
  logic       wr_ready;
  logic [7:0] dec_h, seg_o;
  logic [3:0] an_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_val(wr_val), .wr_blank(wr_blank),
    .dec_b(dec_b), .dec_h(dec_h), .seg_o(seg_o), .an_o(an_o)
  );

  // Board decoder: active-low a..g on bits 7..1, dp on bit 0 (kept dark).
  function automatic logic [7:0] dec7(input logic [2:0] v);
    case (v)
      3'd0:    dec7 = 8'b0000_0011;
      3'd1:    dec7 = 8'b1001_1111;
      3'd2:    dec7 = 8'b0010_0101;
      3'd3:    dec7 = 8'b0000_1101;
      3'd4:    dec7 = 8'b1001_1001;
      3'd5:    dec7 = 8'b0100_1001;
      3'd6:    dec7 = 8'b0100_0001;
      default: dec7 = 8'b0001_1111;
    endcase
  endfunction
  assign dec_h = dec7(dec_b);

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic [2:0] dec_b;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state (slot schedule in terms of edges since enable).
  logic [7:0] SEG_TBL [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
  logic [2:0] m_val   [NDIG];
  logic       m_blank [NDIG];
  bit         m_started = 0;
  bit         m_on = 0;
  int         m_p = 0;
  int         m_ph = -1;
  int         m_ptr = 0;
  logic [2:0] m_cur_val = 3'd0;
  logic       m_cur_blank = 1'b1;
  logic [2:0] m_dec_b = 3'd0;

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_started = 1;
        for (int i = 0; i < NDIG; i++) begin
          m_val[i] = 3'd0;
          m_blank[i] = 1'b1;
        end
        m_on = 0; m_ph = -1; m_ptr = 0; m_dec_b = 3'd0; m_cur_blank = 1'b1;
        e.an = 4'hF; e.seg = 8'hFF; e.dec_b = 3'd0; e.rdy = 1'b0;
        exp_q.push_back(e);
      end else if (m_started) begin
        e.an = 4'hF; e.seg = 8'hFF; e.rdy = 1'b1;
        if (!en) begin
          m_on = 0; m_ph = -1;
        end else if (!m_on) begin
          m_on = 1; m_p = 0; m_ph = -1;
        end else begin
          m_p = m_p + 1;
          m_ph = (m_p - 1) % DIV;
          if (m_ph == 0) begin
            m_cur_val = m_val[m_ptr];
            m_cur_blank = m_blank[m_ptr];
            m_dec_b = m_cur_val;
          end
          if (m_ph >= 1 && m_ph <= DIV - GUARD - 1 && !m_cur_blank) begin
            e.an = ~(4'b0001 << m_ptr);
            e.seg = SEG_TBL[m_cur_val];
          end
          if (m_ph == DIV - 1) m_ptr = (m_ptr + 1) % NDIG;
        end
        e.dec_b = m_dec_b;
        if (wr_valid && int'(wr_idx) < NDIG) begin
          m_val[int'(wr_idx)] = wr_val;
          m_blank[int'(wr_idx)] = wr_blank;
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: one comparison per cycle, away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({an_o, seg_o, dec_b, wr_ready} !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got an=%h seg=%h dec_b=%0d rdy=%b want an=%h seg=%h dec_b=%0d rdy=%b",
                   $time, an_o, seg_o, dec_b, wr_ready, e.an, e.seg, e.dec_b, e.rdy);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] i, input logic [2:0] v, input logic b);
    wr_valid = 1'b1; wr_idx = i; wr_val = v; wr_blank = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Wait (bounded) until the model shows digit dig lit early in its slot.
  task automatic wait_show(input int dig);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (m_on && m_ph >= 2 && m_ph <= 3 && m_ptr == dig) found = 1;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL wait_show timeout digit=%0d", dig);
    end
  endtask

  // Wait (bounded) until the model is in the first guard cycle.
  task automatic wait_guard();
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (m_on && m_ph == DIV - GUARD) found = 1;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL wait_guard timeout");
    end
  endtask

  initial begin : stim
    rst = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_idx = 3'd0; wr_val = 3'd0; wr_blank = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    // Basic scan.
    wr(3'd0, 3'd1, 1'b0); wr(3'd1, 3'd2, 1'b0); wr(3'd2, 3'd3, 1'b0); wr(3'd3, 3'd4, 1'b0);
    en = 1'b1;
    repeat (40) @(negedge clk);
    // Mid-slot write plus an out-of-range write.
    wait_show(1);
    wr(3'd1, 3'd7, 1'b0);
    wr(3'd5, 3'd3, 1'b1);
    repeat (40) @(negedge clk);
    // Blank digit 2.
    wr(3'd2, 3'd6, 1'b1);
    repeat (40) @(negedge clk);
    wr(3'd2, 3'd5, 1'b0);
    repeat (10) @(negedge clk);
    // Enable toggle during digit 2.
    wait_show(2);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    // Reset during guard, released with en high.
    wait_guard();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      wr_valid = ($urandom_range(2) == 0);
      wr_idx   = 3'($urandom_range(7));
      wr_val   = 3'($urandom_range(7));
      wr_blank = ($urandom_range(3) == 0);
      if ($urandom_range(29) == 0) en = ~en;
      rst = ($urandom_range(149) == 0);
      @(negedge clk);
    end
    wr_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
